instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the 8-bit, 2-bit-opcode microprocessor. Owns the program counter, issues requests to instruction memory, and presents each fetched instruction and its opcode field to the control decoder stage over a valid/ready handshake. Accepts branch redirects from the execute stage and discards any fetch that is in flight when a redirect arrives.

## Interface
- PC_W, 8: program counter and instruction-address width.
- INSTR_W, 8: instruction width; opcode is instr[INSTR_W-1 -: 2].
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request; level, held until imem_rvalid.
- imem_addr  out  PC_W  fetch address; stable while imem_req=1.
- imem_rvalid  in  1  response valid; arrives ≥1 cycle after imem_req rises.
- imem_rdata  in  INSTR_W  instruction word, sampled when imem_rvalid=1.
- if_valid  out  1  instruction available to the decoder stage.
- if_ready  in  1  decoder stage accepts.
- if_instr  out  INSTR_W  held instruction.
- if_op  out  2  if_instr[INSTR_W-1 -: 2]: 00 R-type, 01 load, 10 store, 11 branch.
- if_pc  out  PC_W  address of if_instr.
- redirect  in  1  branch taken; single-cycle pulse.
- redirect_target  in  PC_W  new PC, valid when redirect=1.
- fetch_cnt  out  16  accepted instructions (only with IFETCH_PERF_EN).
- redirect_cnt  out  16  redirects received (only with IFETCH_PERF_EN).

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. imem_req = (state==FETCH || state==DRAIN).
- Reset (sampled high at an edge): state IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, counters 0. imem_req=0, imem_addr=RESET_PC. imem_rvalid ignored while reset=1.
- IDLE → FETCH unconditionally.
- FETCH: imem_addr=pc. On rvalid without redirect: capture rdata into if_instr, if_pc=pc, if_valid=1, → HOLD. On redirect without rvalid: pc=target, → DRAIN. On redirect with rvalid: discard data, pc=target, → FETCH.
- DRAIN: imem_addr holds the killed address until rvalid. redirect updates pc (latest target wins). On rvalid: discard data, → FETCH (pc already target).
- HOLD: if_instr/if_pc/if_valid stable while if_ready=0; no request issued. On if_valid&&if_ready: pc=pc+1 (mod 2^PC_W, 8'hFF→8'h00), if_valid=0, → FETCH. On redirect: if_valid=0, pc=target, → FETCH; redirect wins over simultaneous handshake (instruction counted as accepted, next fetch at target, not pc+1).
- Only one request outstanding at any time.

## Timing
- First imem_req=1 in the second cycle after reset deasserts (IDLE cycle, then FETCH).
- Request in cycle t, rvalid in t+1 (minimum): if_valid=1 in t+2.
- Handshake in t+2: next imem_req in t+3 at pc+1. Peak throughput one instruction per 3 cycles.
- Redirect in any cycle: if_valid=0 the following cycle; the first request to target is issued the cycle after the killed response returns (or the next cycle if nothing is outstanding).
- All outputs registered or decoded from state register only; no combinational path from if_ready/redirect to imem_req.

## Configuration
- IFETCH_PERF_EN defined: fetch_cnt increments on each if_valid&&if_ready; redirect_cnt on each redirect. Both 16-bit, wrap at 16'hFFFF, cleared by reset.
- Undefined: fetch_cnt/redirect_cnt ports and logic absent; all other behaviour identical.

## Structure
- Package ifetch_pkg: state enum (IDLE, FETCH, HOLD, DRAIN); opcode localparams OP_RTYPE=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10, OP_BRANCH=2'b11; opcode field position.
- Sub-module ifetch_perf: the two counters, instantiated only under IFETCH_PERF_EN.

## Test plan
- Reset release, 1-cycle memory, mem[0]=8'h12, mem[1]=8'h56, if_ready=1 → imem_req rises in cycle 2; if_instr=8'h12/if_pc=0/if_op=00, then 8'h56/if_pc=1/if_op=01, 3 cycles apart.
- Backpressure: if_ready=0 for 5 cycles in HOLD → if_instr/if_pc constant, imem_req=0 throughout; release → next imem_addr=pc+1.
- 3-cycle memory, redirect to 8'h40 one cycle after request → old response discarded (if_valid stays 0), imem_addr holds old address until rvalid, next request at 8'h40.
- Redirect to 8'h20 in the same cycle as handshake of pc=8'h05 → next imem_addr=8'h20, not 8'h06; fetch_cnt +1, redirect_cnt +1 (IFETCH_PERF_EN).
- Redirect to 8'hFF, accept that instruction → next imem_addr=8'h00.
- Reset asserted during DRAIN → if_valid=0, counters 0, first request after release at RESET_PC; late rvalid during reset ignored.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The opcode occupies the top OP_W bits of every instruction word.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE  = 2'b00;
    localparam logic [OP_W-1:0] OP_LOAD   = 2'b01;
    localparam logic [OP_W-1:0] OP_STORE  = 2'b10;
    localparam logic [OP_W-1:0] OP_BRANCH = 2'b11;

endpackage

// File: rtl/ifetch_perf.sv
// Fetch-stage event counters: accepted instructions and branch redirects.
// Both wrap at 16'hFFFF; only instantiated when IFETCH_PERF_EN is defined.
module ifetch_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic        redirect,
    output logic [15:0] fetch_cnt,
    output logic [15:0] redirect_cnt
);

    // Count handshakes and redirects; cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt    <= 16'd0;
            redirect_cnt <= 16'd0;
        end else begin
            if (accept) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (redirect) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time
// and hands each instruction to the decoder over valid/ready.
// A redirect kills any in-flight fetch; the killed response is drained
// before the first request to the new target goes out.
// Optional macro IFETCH_PERF_EN adds fetch_cnt / redirect_cnt counters.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int                PC_W     = 8,
    parameter int                INSTR_W  = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [OP_W-1:0]    if_op,
    output logic [PC_W-1:0]    if_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_target
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        redirect_cnt
`endif
);

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic [PC_W-1:0]   addr_q;
    logic              accept;
    logic              capture;
    logic              clear_valid;

    assign accept = if_valid && if_ready;

    // Next-state, next-PC and instruction capture/clear decisions.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
                if (redirect) begin
                    pc_next = redirect_target;
                end
            end
            FETCH: begin
                if (redirect) begin
                    // Response arriving with the redirect is simply dropped;
                    // otherwise it is still owed and must be drained.
                    pc_next    = redirect_target;
                    state_next = imem_rvalid ? FETCH : DRAIN;
                end else if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_next = redirect_target;
                end
                if (imem_rvalid) begin
                    state_next = FETCH;
                end
            end
            HOLD: begin
                // Redirect wins over a simultaneous handshake.
                if (redirect) begin
                    pc_next     = redirect_target;
                    state_next  = FETCH;
                    clear_valid = 1'b1;
                end else if (accept) begin
                    pc_next     = pc + PC_W'(1);
                    state_next  = FETCH;
                    clear_valid = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, PC and request-address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            // While draining, the address of the killed request stays on the bus.
            if (state_next != DRAIN) begin
                addr_q <= pc_next;
            end
        end
    end

    // Output instruction holding register toward the decoder.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (capture) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc;
        end else if (clear_valid) begin
            if_valid <= 1'b0;
        end
    end

    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = addr_q;
    assign if_op     = if_instr[INSTR_W-1 -: OP_W];

`ifdef IFETCH_PERF_EN
    ifetch_perf u_perf (
        .clk          (clk),
        .reset        (reset),
        .accept       (accept),
        .redirect     (redirect),
        .fetch_cnt    (fetch_cnt),
        .redirect_cnt (redirect_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a variable-latency memory model.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_rvalid = 1'b0;
    logic [7:0] imem_rdata  = 8'h00;
    logic       if_valid;
    logic       if_ready;
    logic [7:0] if_instr;
    logic [1:0] if_op;
    logic [7:0] if_pc;
    logic       redirect;
    logic [7:0] redirect_target;
`ifdef IFETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] redirect_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [0:255];
    int         mem_lat = 1;
    bit         busy    = 1'b0;
    int         wait_c  = 0;
    logic [7:0] addr_l  = 8'h00;

    always #5 clk = ~clk;

    instr_fetch #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_op           (if_op),
        .if_pc           (if_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_cnt       (fetch_cnt),
        .redirect_cnt    (redirect_cnt)
`endif
    );

    // Memory model: latches a request at the falling edge, answers mem_lat
    // cycles later with a one-cycle rvalid pulse; keeps running through reset.
    always @(negedge clk) begin
        if (imem_rvalid) begin
            imem_rvalid = 1'b0;
            busy        = 1'b0;
        end else if (busy) begin
            wait_c = wait_c - 1;
            if (wait_c == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem[addr_l];
            end
        end else if (imem_req === 1'b1) begin
            busy   = 1'b1;
            wait_c = mem_lat;
            addr_l = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max_cycles; i++) begin
            if (if_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; if_ready = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_instr !== 8'h00) begin n_err++; $display("FAIL rst_instr: got %h want 00", if_instr); end
        n_cmp++; if (if_pc !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h want 00", if_pc); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
`ifdef IFETCH_PERF_EN
        n_cmp++; if (fetch_cnt !== 16'd0 || redirect_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", fetch_cnt, redirect_cnt); end
`endif
        reset = 1'b0;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
        tick();
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL first_addr: got %h want 00", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        if_ready = 1'b1;
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL early_valid: got %b want 0", if_valid); end
        tick();
        n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL i0_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_instr !== 8'h12) begin n_err++; $display("FAIL i0_instr: got %h want 12", if_instr); end
        n_cmp++; if (if_pc !== 8'h00) begin n_err++; $display("FAIL i0_pc: got %h want 00", if_pc); end
        n_cmp++; if (if_op !== 2'b00) begin n_err++; $display("FAIL i0_op: got %b want 00", if_op); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", imem_req); end
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin n_err++; $display("FAIL i1_req: got %b/%h want 1/01", imem_req, imem_addr); end
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL i1_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_instr !== 8'h56) begin n_err++; $display("FAIL i1_instr: got %h want 56", if_instr); end
        n_cmp++; if (if_pc !== 8'h01) begin n_err++; $display("FAIL i1_pc: got %h want 01", if_pc); end
        n_cmp++; if (if_op !== 2'b01) begin n_err++; $display("FAIL i1_op: got %b want 01", if_op); end
        if_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_instr !== 8'h56 || if_pc !== 8'h01 || imem_req !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b i=%h pc=%h req=%b want 1/56/01/0", i, if_valid, if_instr, if_pc, imem_req); end
        end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h02) begin n_err++; $display("FAIL bp_next: got %b/%h want 1/02", imem_req, imem_addr); end
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL bp_clear: got %b want 0", if_valid); end
        wait_valid(10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: got no if_valid want if_valid"); end
        n_cmp++; if (if_instr !== 8'h9A || if_pc !== 8'h02 || if_op !== 2'b10) begin n_err++; $display("FAIL i2: got %h/%h/%b want 9a/02/10", if_instr, if_pc, if_op); end
    endtask

    task automatic test_redirect_inflight();
        bit ok;
        mem_lat = 3;
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h03) begin n_err++; $display("FAIL rd_req: got %b/%h want 1/03", imem_req, imem_addr); end
        tick();
        redirect = 1'b1; redirect_target = 8'h40;
        tick();
        redirect = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h03 || if_valid !== 1'b0) begin n_err++; $display("FAIL rd_drain0: got %b/%h/%b want 1/03/0", imem_req, imem_addr, if_valid); end
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h03 || if_valid !== 1'b0) begin n_err++; $display("FAIL rd_drain1: got %b/%h/%b want 1/03/0", imem_req, imem_addr, if_valid); end
        tick();
        mem_lat = 1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || if_valid !== 1'b0) begin n_err++; $display("FAIL rd_target: got %b/%h/%b want 1/40/0", imem_req, imem_addr, if_valid); end
        wait_valid(10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_timeout: got no if_valid want if_valid"); end
        n_cmp++; if (if_instr !== 8'hC3 || if_pc !== 8'h40 || if_op !== 2'b11) begin n_err++; $display("FAIL rd_instr: got %h/%h/%b want c3/40/11", if_instr, if_pc, if_op); end
    endtask

    task automatic test_redirect_handshake();
        bit ok;
        redirect = 1'b1; redirect_target = 8'h05;
        tick();
        redirect = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h05) begin n_err++; $display("FAIL rh_hold_redirect: got %b/%b/%h want 0/1/05", if_valid, imem_req, imem_addr); end
        wait_valid(10, ok);
        n_cmp++; if (!ok || if_instr !== 8'h47 || if_pc !== 8'h05 || if_op !== 2'b01) begin n_err++; $display("FAIL rh_i5: got %b/%h/%h/%b want 1/47/05/01", ok, if_instr, if_pc, if_op); end
        if_ready = 1'b1; redirect = 1'b1; redirect_target = 8'h20;
        tick();
        if_ready = 1'b0; redirect = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h20 || if_valid !== 1'b0) begin n_err++; $display("FAIL rh_target: got %b/%h/%b want 1/20/0", imem_req, imem_addr, if_valid); end
`ifdef IFETCH_PERF_EN
        n_cmp++; if (fetch_cnt !== 16'd4 || redirect_cnt !== 16'd3) begin n_err++; $display("FAIL rh_cnt: got %0d/%0d want 4/3", fetch_cnt, redirect_cnt); end
`endif
        wait_valid(10, ok);
        n_cmp++; if (!ok || if_instr !== 8'h8E || if_pc !== 8'h20) begin n_err++; $display("FAIL rh_i20: got %b/%h/%h want 1/8e/20", ok, if_instr, if_pc); end
    endtask

    task automatic test_pc_wrap();
        bit ok;
        redirect = 1'b1; redirect_target = 8'hFF;
        tick();
        redirect = 1'b0;
        wait_valid(10, ok);
        n_cmp++; if (!ok || if_instr !== 8'hD1 || if_pc !== 8'hFF || if_op !== 2'b11) begin n_err++; $display("FAIL wrap_iff: got %b/%h/%h/%b want 1/d1/ff/11", ok, if_instr, if_pc, if_op); end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_err++; $display("FAIL wrap_addr: got %b/%h want 1/00", imem_req, imem_addr); end
        wait_valid(10, ok);
        n_cmp++; if (!ok || if_instr !== 8'h12 || if_pc !== 8'h00) begin n_err++; $display("FAIL wrap_i0: got %b/%h/%h want 1/12/00", ok, if_instr, if_pc); end
`ifdef IFETCH_PERF_EN
        n_cmp++; if (fetch_cnt !== 16'd5 || redirect_cnt !== 16'd4) begin n_err++; $display("FAIL wrap_cnt: got %0d/%0d want 5/4", fetch_cnt, redirect_cnt); end
`endif
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        mem_lat = 3;
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0; redirect = 1'b1; redirect_target = 8'h40;
        tick();
        redirect = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin n_err++; $display("FAIL rsd_drain: got %b/%h want 1/01", imem_req, imem_addr); end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h00) begin n_err++; $display("FAIL rsd_state: got %b/%b/%h want 0/0/00", if_valid, imem_req, imem_addr); end
`ifdef IFETCH_PERF_EN
        n_cmp++; if (fetch_cnt !== 16'd0 || redirect_cnt !== 16'd0) begin n_err++; $display("FAIL rsd_cnt: got %0d/%0d want 0/0", fetch_cnt, redirect_cnt); end
`endif
        reset = 1'b0; mem_lat = 1;
        n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL rsd_idle: got %b/%b want 0/0", imem_req, if_valid); end
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_err++; $display("FAIL rsd_first: got %b/%h want 1/00", imem_req, imem_addr); end
        wait_valid(10, ok);
        n_cmp++; if (!ok || if_instr !== 8'h12 || if_pc !== 8'h00) begin n_err++; $display("FAIL rsd_i0: got %b/%h/%h want 1/12/00", ok, if_instr, if_pc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h12; mem[8'h01] = 8'h56; mem[8'h02] = 8'h9A; mem[8'h03] = 8'hBB;
        mem[8'h05] = 8'h47; mem[8'h20] = 8'h8E; mem[8'h40] = 8'hC3; mem[8'hFF] = 8'hD1;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_handshake();
        test_pc_wrap();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
